// File: rtl/clk_enable_pkg.sv
`default_nettype none
// ============================================================================
// Package  : clk_enable_pkg
// Purpose  : Shared FSM state type and reconfiguration validity rule for the
//            clk_enable_pll block.
// Contents : pll_state_t   - LOCKING / LOCKED state encoding
//            cfg_is_valid  - accept/reject rule for a channel reconfig
// Revision : 1.0 - initial release
// ============================================================================
package clk_enable_pkg;

    typedef enum logic [0:0] {
        ST_LOCKING = 1'b0,
        ST_LOCKED  = 1'b1
    } pll_state_t;

    localparam int c_CFG_CH_W = 3;

    // Arguments are zero-extended to 32 bits by the caller so the rule can be
    // shared by any ACC_W up to 32.
    function automatic logic cfg_is_valid(
        input logic [31:0]           mult,
        input logic [31:0]           div,
        input logic [31:0]           phase,
        input logic [c_CFG_CH_W-1:0] ch,
        input logic [31:0]           num_ch
    );
        return (div != 32'd0) && (mult <= div) && (phase < div) &&
               (32'(ch) < num_ch);
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_enable_chan.sv
`default_nettype none
// ============================================================================
// Module   : clk_enable_chan
// Purpose  : One fractional clock-enable channel: holds mult/div/phase, a
//            phase accumulator and the registered enable flop.
// Ports    : clk      - reference clock (rising edge)
//            rst      - asynchronous active-high reset
//            i_wr     - write new config and preload accumulator with phase
//            i_load   - reload accumulator from stored phase, enable low
//            i_step   - advance accumulator by mult, emit enable on wrap
//            i_mult / i_div / i_phase - new config values
//            o_en     - clock-enable pulse
// Revision : 1.0 - initial release
// ============================================================================
module clk_enable_chan #(
    parameter int ACC_W     = 16,
    parameter int DEF_MULT  = 1,
    parameter int DEF_DIV   = 1,
    parameter int DEF_PHASE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [ACC_W-1:0] i_mult,
    input  logic [ACC_W-1:0] i_div,
    input  logic [ACC_W-1:0] i_phase,
    output logic             o_en
);

    logic [ACC_W-1:0] r_mult;
    logic [ACC_W-1:0] r_div;
    logic [ACC_W-1:0] r_phase;
    logic [ACC_W-1:0] r_acc;
    logic             r_en;
    logic [ACC_W:0]   w_sum;

    // One extra bit so acc+mult never overflows before the compare.
    assign w_sum = {1'b0, r_acc} + {1'b0, r_mult};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mult  <= ACC_W'(DEF_MULT);
            r_div   <= ACC_W'(DEF_DIV);
            r_phase <= ACC_W'(DEF_PHASE);
            r_acc   <= ACC_W'(DEF_PHASE);
            r_en    <= 1'b0;
        end else if (i_wr) begin
            r_mult  <= i_mult;
            r_div   <= i_div;
            r_phase <= i_phase;
            r_acc   <= i_phase;
            r_en    <= 1'b0;
        end else if (i_load) begin
            r_acc   <= r_phase;
            r_en    <= 1'b0;
        end else if (i_step) begin
            if (w_sum >= {1'b0, r_div}) begin
                // acc < div and mult <= div, so the difference fits in ACC_W
                // bits and modular subtraction on the low bits is exact.
                r_acc <= w_sum[ACC_W-1:0] - r_div;
                r_en  <= 1'b1;
            end else begin
                r_acc <= w_sum[ACC_W-1:0];
                r_en  <= 1'b0;
            end
        end else begin
            r_en <= 1'b0;
        end
    end

    assign o_en = r_en;

endmodule
`default_nettype wire

// File: rtl/clk_enable_pll.sv
`default_nettype none
// ============================================================================
// Module   : clk_enable_pll
// Purpose  : "Digital PLL" producing NUM_CH fractional clock-enable streams
//            from refclk. After reset or any accepted reconfiguration the
//            block relocks for LOCK_CYCLES cycles before enables are valid.
// Ports    : refclk    - only clock, rising edge
//            rst       - asynchronous active-high reset
//            cfg_valid - reconfig request
//            cfg_ready - high whenever LOCKED (request can be taken)
//            cfg_ch    - target channel
//            cfg_mult / cfg_div / cfg_phase - new ratio and phase
//            cfg_err   - one-cycle pulse on a rejected request
//            outclk_en - per-channel clock-enable pulses
//            locked    - enables are valid
// Revision : 1.0 - initial release
// ============================================================================
module clk_enable_pll
    import clk_enable_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int ACC_W       = 16,
    parameter int LOCK_CYCLES = 64,
    parameter int DEF_MULT    = 1,
    parameter int DEF_DIV     = 1,
    parameter int DEF_PHASE   = 0
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [2:0]        cfg_ch,
    input  logic [ACC_W-1:0]  cfg_mult,
    input  logic [ACC_W-1:0]  cfg_div,
    input  logic [ACC_W-1:0]  cfg_phase,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] outclk_en,
    output logic              locked
);

    localparam int                 c_CNT_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(LOCK_CYCLES - 1);

    pll_state_t         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_locked;
    logic               r_cfg_err;

    logic               w_cfg_ok;
    logic               w_accept;
    logic               w_last;
    logic               w_step;
    logic               w_load;
    logic [NUM_CH-1:0]  w_en;

    assign w_cfg_ok = cfg_is_valid(32'(cfg_mult), 32'(cfg_div), 32'(cfg_phase),
                                   cfg_ch, 32'(NUM_CH));

    assign cfg_ready = (r_state == ST_LOCKED);
    assign w_accept  = cfg_valid && cfg_ready && w_cfg_ok;
    assign w_last    = (r_state == ST_LOCKING) && (r_cnt == c_CNT_LAST);

    // The final LOCKING edge already advances the accumulators so that the
    // first cycle with locked=1 carries a valid enable.
    assign w_step = ((r_state == ST_LOCKED) && !w_accept) || w_last;
    assign w_load = ((r_state == ST_LOCKING) && !w_last) || w_accept;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_LOCKING;
            r_cnt     <= '0;
            r_locked  <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            case (r_state)
                ST_LOCKING: begin
                    r_cfg_err <= 1'b0;
                    if (w_last) begin
                        r_state  <= ST_LOCKED;
                        r_locked <= 1'b1;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                ST_LOCKED: begin
                    if (w_accept) begin
                        r_state   <= ST_LOCKING;
                        r_locked  <= 1'b0;
                        r_cnt     <= '0;
                        r_cfg_err <= 1'b0;
                    end else begin
                        r_cfg_err <= cfg_valid && !w_cfg_ok;
                    end
                end
                default: begin
                    r_state   <= ST_LOCKING;
                    r_cnt     <= '0;
                    r_locked  <= 1'b0;
                    r_cfg_err <= 1'b0;
                end
            endcase
        end
    end

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
            clk_enable_chan #(
                .ACC_W     (ACC_W),
                .DEF_MULT  (DEF_MULT),
                .DEF_DIV   (DEF_DIV),
                .DEF_PHASE (DEF_PHASE)
            ) u_chan (
                .clk     (refclk),
                .rst     (rst),
                .i_wr    (w_accept && (cfg_ch == 3'(i))),
                .i_load  (w_load),
                .i_step  (w_step),
                .i_mult  (cfg_mult),
                .i_div   (cfg_div),
                .i_phase (cfg_phase),
                .o_en    (w_en[i])
            );
        end
    endgenerate

    assign outclk_en = w_en;
    assign cfg_err   = r_cfg_err;
    assign locked    = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_clk_enable_pll.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_enable_pll
// Purpose  : Self-checking bench for clk_enable_pll. A reference model counts
//            cycles since the last relock and derives each enable from the
//            closed form floor((p+k*m)/d) - floor((p+(k-1)*m)/d).
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_enable_pll;

    localparam int c_NUM_CH = 4;
    localparam int c_ACC_W  = 16;
    localparam int c_LOCK   = 64;
    localparam int c_OUT_W  = c_NUM_CH + 3;

    logic                refclk    = 1'b0;
    logic                rst       = 1'b1;
    logic                cfg_valid = 1'b0;
    logic [2:0]          cfg_ch    = '0;
    logic [c_ACC_W-1:0]  cfg_mult  = '0;
    logic [c_ACC_W-1:0]  cfg_div   = '0;
    logic [c_ACC_W-1:0]  cfg_phase = '0;
    wire                 cfg_ready;
    wire                 cfg_err;
    wire                 locked;
    wire [c_NUM_CH-1:0]  outclk_en;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    longint m_mult  [8];
    longint m_div   [8];
    longint m_phase [8];
    int     m_n;        // edges since LOCKING was entered
    logic   m_err;

    clk_enable_pll #(
        .NUM_CH      (c_NUM_CH),
        .ACC_W       (c_ACC_W),
        .LOCK_CYCLES (c_LOCK),
        .DEF_MULT    (1),
        .DEF_DIV     (1),
        .DEF_PHASE   (0)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_mult  (cfg_mult),
        .cfg_div   (cfg_div),
        .cfg_phase (cfg_phase),
        .cfg_err   (cfg_err),
        .outclk_en (outclk_en),
        .locked    (locked)
    );

    always #5 refclk = ~refclk;

    function automatic bit req_ok();
        return (cfg_ch < 3'(c_NUM_CH)) && (cfg_div != '0) &&
               (cfg_mult <= cfg_div) && (cfg_phase < cfg_div);
    endfunction

    always @(posedge refclk or posedge rst) begin
        if (rst) begin
            m_n   <= 0;
            m_err <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                m_mult[i]  <= 1;
                m_div[i]   <= 1;
                m_phase[i] <= 0;
            end
        end else if (m_n >= c_LOCK) begin
            if (cfg_valid && req_ok()) begin
                m_mult[cfg_ch]  <= longint'(cfg_mult);
                m_div[cfg_ch]   <= longint'(cfg_div);
                m_phase[cfg_ch] <= longint'(cfg_phase);
                m_n   <= 0;
                m_err <= 1'b0;
            end else begin
                m_n   <= m_n + 1;
                m_err <= cfg_valid;
            end
        end else begin
            m_n   <= m_n + 1;
            m_err <= 1'b0;
        end
    end

    // Expected {locked, cfg_ready, cfg_err, outclk_en}
    function automatic logic [c_OUT_W-1:0] exp_out();
        logic [c_NUM_CH-1:0] e;
        longint k;
        e = '0;
        if (m_n >= c_LOCK) begin
            k = longint'(m_n - c_LOCK + 1);
            for (int i = 0; i < c_NUM_CH; i++)
                e[i] = ((m_phase[i] + k * m_mult[i]) / m_div[i]) !=
                       ((m_phase[i] + (k - 1) * m_mult[i]) / m_div[i]);
        end
        return {m_n >= c_LOCK, m_n >= c_LOCK, m_err, e};
    endfunction

    // Presents a request for exactly one edge; returns at the following negedge.
    task automatic pulse_req(input int ch, input int m, input int d, input int p);
        cfg_ch    = 3'(ch);
        cfg_mult  = c_ACC_W'(m);
        cfg_div   = c_ACC_W'(d);
        cfg_phase = c_ACC_W'(p);
        cfg_valid = 1'b1;
        @(negedge refclk);
        cfg_valid = 1'b0;
    endtask

    // Advances until locked is seen (bounded); returns edges consumed.
    task automatic wait_lock(output int cyc);
        cyc = 0;
        while (locked !== 1'b1 && cyc < 300) begin
            @(negedge refclk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        int cyc;
        rst = 1'b1;
        repeat (3) @(negedge refclk);
        n_checks++;
        if ({locked, cfg_ready, cfg_err, outclk_en} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got %b want 0", {locked, cfg_ready, cfg_err, outclk_en});
        end
        rst = 1'b0;
        wait_lock(cyc);
        n_checks++;
        if (cyc != c_LOCK) begin
            n_fail++;
            $display("FAIL reset_lock_time: got %0d cycles want %0d", cyc, c_LOCK);
        end
        for (int c = 0; c < 20; c++) begin
            n_checks++;
            if (outclk_en !== 4'b1111 || {locked, cfg_ready, cfg_err, outclk_en} !== exp_out()) begin
                n_fail++;
                $display("FAIL reset_default_en cyc %0d: got %b want %b", c,
                         {locked, cfg_ready, cfg_err, outclk_en}, exp_out());
            end
            @(negedge refclk);
        end
    endtask

    task automatic test_ratio_ch0();
        int cyc, cnt;
        pulse_req(0, 30, 31, 0);
        n_checks++;
        if (locked !== 1'b0 || outclk_en !== '0) begin
            n_fail++;
            $display("FAIL ch0_relock_drop: got locked=%b en=%b want 0/0", locked, outclk_en);
        end
        wait_lock(cyc);
        n_checks++;
        if (cyc != c_LOCK) begin
            n_fail++;
            $display("FAIL ch0_lock_time: got %0d want %0d", cyc, c_LOCK);
        end
        n_checks++;
        if (outclk_en[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL ch0_first_cycle: got %b want 0", outclk_en[0]);
        end
        cnt = 0;
        for (int c = 0; c < 93; c++) begin
            n_checks++;
            if ({locked, cfg_ready, cfg_err, outclk_en} !== exp_out()) begin
                n_fail++;
                $display("FAIL ch0_pattern cyc %0d: got %b want %b", c,
                         {locked, cfg_ready, cfg_err, outclk_en}, exp_out());
            end
            cnt += int'(outclk_en[0]);
            if (c % 31 == 30) begin
                n_checks++;
                if (cnt != 30) begin
                    n_fail++;
                    $display("FAIL ch0_window_count: got %0d want 30", cnt);
                end
                cnt = 0;
            end
            @(negedge refclk);
        end
    endtask

    task automatic test_ratio_ch1();
        int cyc, first, cnt;
        pulse_req(1, 1, 4, 2);
        wait_lock(cyc);
        n_checks++;
        if (cyc != c_LOCK) begin
            n_fail++;
            $display("FAIL ch1_lock_time: got %0d want %0d", cyc, c_LOCK);
        end
        first = 0;
        cnt   = 0;
        for (int c = 1; c <= 20; c++) begin
            n_checks++;
            if ({locked, cfg_ready, cfg_err, outclk_en} !== exp_out()) begin
                n_fail++;
                $display("FAIL ch1_pattern cyc %0d: got %b want %b", c,
                         {locked, cfg_ready, cfg_err, outclk_en}, exp_out());
            end
            if (outclk_en[1] === 1'b1) begin
                cnt++;
                if (first == 0) first = c;
            end
            @(negedge refclk);
        end
        n_checks++;
        if (first != 2) begin
            n_fail++;
            $display("FAIL ch1_first_pulse: got cycle %0d want 2", first);
        end
        n_checks++;
        if (cnt != 5) begin
            n_fail++;
            $display("FAIL ch1_pulse_count: got %0d want 5", cnt);
        end
    endtask

    task automatic test_invalid();
        int bad [4][4] = '{'{0, 1, 0, 0}, '{2, 5, 4, 0}, '{1, 1, 4, 4}, '{5, 1, 2, 0}};
        for (int r = 0; r < 4; r++) begin
            pulse_req(bad[r][0], bad[r][1], bad[r][2], bad[r][3]);
            n_checks++;
            if (cfg_err !== 1'b1 || locked !== 1'b1 ||
                {locked, cfg_ready, cfg_err, outclk_en} !== exp_out()) begin
                n_fail++;
                $display("FAIL invalid_err_pulse req %0d: got err=%b locked=%b out=%b want %b", r,
                         cfg_err, locked, {locked, cfg_ready, cfg_err, outclk_en}, exp_out());
            end
            for (int c = 0; c < 6; c++) begin
                @(negedge refclk);
                n_checks++;
                if (cfg_err !== 1'b0 || {locked, cfg_ready, cfg_err, outclk_en} !== exp_out()) begin
                    n_fail++;
                    $display("FAIL invalid_after req %0d cyc %0d: got %b want %b", r, c,
                             {locked, cfg_ready, cfg_err, outclk_en}, exp_out());
                end
            end
        end
    endtask

    task automatic test_hold_locking();
        int cyc;
        pulse_req(2, 3, 7, 1);
        cfg_ch    = 3'd3;
        cfg_mult  = c_ACC_W'(2);
        cfg_div   = c_ACC_W'(5);
        cfg_phase = c_ACC_W'(4);
        cfg_valid = 1'b1;
        cyc = 0;
        while (cfg_ready !== 1'b1 && cyc < 300) begin
            n_checks++;
            if (cfg_err !== 1'b0 || outclk_en !== '0) begin
                n_fail++;
                $display("FAIL hold_locking cyc %0d: got err=%b en=%b want 0/0", cyc, cfg_err, outclk_en);
            end
            @(negedge refclk);
            cyc++;
        end
        n_checks++;
        if (cyc != c_LOCK) begin
            n_fail++;
            $display("FAIL hold_ready_time: got %0d want %0d", cyc, c_LOCK);
        end
        @(negedge refclk);
        cfg_valid = 1'b0;
        n_checks++;
        if (locked !== 1'b0 || {locked, cfg_ready, cfg_err, outclk_en} !== exp_out()) begin
            n_fail++;
            $display("FAIL hold_accept: got %b want %b",
                     {locked, cfg_ready, cfg_err, outclk_en}, exp_out());
        end
        wait_lock(cyc);
        for (int c = 0; c < 40; c++) begin
            n_checks++;
            if ({locked, cfg_ready, cfg_err, outclk_en} !== exp_out()) begin
                n_fail++;
                $display("FAIL hold_pattern cyc %0d: got %b want %b", c,
                         {locked, cfg_ready, cfg_err, outclk_en}, exp_out());
            end
            @(negedge refclk);
        end
    endtask

    task automatic test_rst_mid();
        int cyc;
        pulse_req(0, 1, 3, 0);
        repeat (30) @(negedge refclk);
        rst = 1'b1;
        @(negedge refclk);
        rst = 1'b0;
        wait_lock(cyc);
        n_checks++;
        if (cyc != c_LOCK) begin
            n_fail++;
            $display("FAIL rst_midlock_time: got %0d want %0d", cyc, c_LOCK);
        end
        repeat (10) @(negedge refclk);
        rst = 1'b1;
        @(negedge refclk);
        n_checks++;
        if ({locked, cfg_ready, cfg_err, outclk_en} !== '0) begin
            n_fail++;
            $display("FAIL rst_midop_state: got %b want 0", {locked, cfg_ready, cfg_err, outclk_en});
        end
        rst = 1'b0;
        wait_lock(cyc);
        n_checks++;
        if (cyc != c_LOCK || outclk_en !== 4'b1111) begin
            n_fail++;
            $display("FAIL rst_midop_relock: got %0d cycles en=%b want %0d cycles en=1111",
                     cyc, outclk_en, c_LOCK);
        end
    endtask

    task automatic test_random();
        int d;
        for (int c = 0; c < 2500; c++) begin
            n_checks++;
            if ({locked, cfg_ready, cfg_err, outclk_en} !== exp_out()) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %b want %b", c,
                         {locked, cfg_ready, cfg_err, outclk_en}, exp_out());
            end
            if ($urandom_range(0, 24) == 0) begin
                d         = int'($urandom_range(0, 12));
                cfg_div   = c_ACC_W'(d);
                cfg_mult  = c_ACC_W'($urandom_range(0, d + 1));
                cfg_phase = c_ACC_W'($urandom_range(0, d));
                cfg_ch    = 3'($urandom_range(0, 5));
                cfg_valid = 1'b1;
            end else begin
                cfg_valid = 1'b0;
            end
            @(negedge refclk);
        end
        cfg_valid = 1'b0;
    endtask

    initial begin
        @(negedge refclk);
        test_reset();
        test_ratio_ch0();
        test_ratio_ch1();
        test_invalid();
        test_hold_locking();
        test_rst_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
